// File: rtl/rst_sequencer.sv
// rst_sequencer: drives the DUT's active-low reset from a master synchronous
// reset and from software reset requests. It guarantees a minimum low time
// and a release-to-ready delay, and keeps a saturating count of completed
// sequences.
// Optional watchdog: define RST_SEQ_WDOG_EN to add i_wdog_kick/o_wdog_fired.
// Without it the watchdog ports and logic are absent and WDOG_CYCLES is unused.
module rst_sequencer #(
    parameter int unsigned ASSERT_CYCLES  = 16,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned WDOG_CYCLES    = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sw_rst_req,
    output logic             o_sw_rst_ack,
    output logic             o_rst_n,
    output logic             o_rst_done,
    output logic [CNT_W-1:0] o_rst_count
`ifdef RST_SEQ_WDOG_EN
    ,
    input  logic             i_wdog_kick,
    output logic             o_wdog_fired
`endif
);

    // One phase counter serves both timed states.
    localparam int unsigned PH_MAX =
        (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES : RELEASE_CYCLES;
    localparam int unsigned PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  ASSERT_LAST  = PH_W'(ASSERT_CYCLES - 1);
    localparam logic [PH_W-1:0]  RELEASE_LAST = PH_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_req_q;
    logic             r_ack;
    logic             r_rst_n;
    logic             r_done;
    logic             w_req_edge;
    logic             w_expire;

    // A held request is accepted only on the cycle it first appears high.
    assign w_req_edge = i_sw_rst_req & ~r_req_q;

`ifdef RST_SEQ_WDOG_EN
    localparam int unsigned      WD_W      = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0]  WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] r_wdog;
    logic [WD_W-1:0] w_wdog_nxt;
    logic            r_fired;

    // A kick in the expiry cycle wins, so it is part of the expiry condition.
    assign w_expire = (r_state == ST_RUN) && !i_wdog_kick && (r_wdog == WDOG_LAST);

    // Watchdog counts idle RUN cycles; anything else clears it.
    always_comb begin
        w_wdog_nxt = r_wdog + WD_W'(1);
        if ((r_state != ST_RUN) || i_wdog_kick || w_expire) begin
            w_wdog_nxt = '0;
        end
    end

    // Watchdog counter and sticky expiry flag; only the master reset clears the flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog  <= '0;
            r_fired <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            if (w_expire) begin
                r_fired <= 1'b1;
            end
        end
    end

    assign o_wdog_fired = r_fired;
`else
    logic w_unused_wdog;

    assign w_expire      = 1'b0;
    assign w_unused_wdog = ^WDOG_CYCLES;
`endif

    // Next-state logic; a restart (request or watchdog) overrides the phase walk.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + PH_W'(1);
        w_count_nxt = r_count;
        case (r_state)
            ST_ASSERT: begin
                if (r_phase == ASSERT_LAST) begin
                    w_state_nxt = ST_RELEASE;
                    w_phase_nxt = '0;
                end
            end
            ST_RELEASE: begin
                if (r_phase == RELEASE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = '0;
                    if (r_count != COUNT_MAX) begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                w_phase_nxt = r_phase;
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_phase_nxt = '0;
            end
        endcase
        // An aborted release must not count as a completed sequence.
        if (w_req_edge || w_expire) begin
            w_state_nxt = ST_ASSERT;
            w_phase_nxt = '0;
            w_count_nxt = r_count;
        end
    end

    // State, counters and output flops; outputs are decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_ASSERT;
            r_phase <= '0;
            r_count <= '0;
            r_req_q <= 1'b0;
            r_ack   <= 1'b0;
            r_rst_n <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
            r_req_q <= i_sw_rst_req;
            r_ack   <= w_req_edge;
            r_rst_n <= (w_state_nxt != ST_ASSERT);
            r_done  <= (w_state_nxt == ST_RUN);
        end
    end

    assign o_sw_rst_ack = r_ack;
    assign o_rst_n      = r_rst_n;
    assign o_rst_done   = r_done;
    assign o_rst_count  = r_count;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: directed scenarios with timing taken from the
// sequence rules, then randomized traffic against a cycle-count model.
`timescale 1ns/1ps
module tb_rst_sequencer;

    localparam int unsigned A    = 16;
    localparam int unsigned R    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef RST_SEQ_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req;
    logic          kick;
    logic          ack;
    logic          rst_n;
    logic          done;
    logic [CW-1:0] count;
    logic          fired;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycles elapsed since the last restart decides everything.
    int m_el    = 0;
    int m_count = 0;
    int m_idle  = 0;
    bit m_prev  = 1'b0;
    bit m_ack   = 1'b0;
    bit m_fired = 1'b0;

    rst_sequencer #(
        .ASSERT_CYCLES (A),
        .RELEASE_CYCLES(R),
        .WDOG_CYCLES   (W),
        .CNT_W         (CW)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw_rst_req(req),
        .o_sw_rst_ack(ack),
        .o_rst_n     (rst_n),
        .o_rst_done  (done),
        .o_rst_count (count)
`ifdef RST_SEQ_WDOG_EN
        ,
        .i_wdog_kick (kick),
        .o_wdog_fired(fired)
`endif
    );

`ifndef RST_SEQ_WDOG_EN
    assign fired = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: update the model with the inputs seen at this edge.
    task automatic cyc();
        bit accept;
        bit in_run;
        bit expire;
        if (rst) begin
            m_el = 0; m_count = 0; m_prev = 0; m_ack = 0; m_fired = 0; m_idle = 0;
        end else begin
            accept = req && !m_prev;
            m_prev = req;
            in_run = (m_el >= int'(A + R));
            expire = WD_EN && in_run && !kick && (m_idle == int'(W) - 1);
            if (accept || expire) begin
                m_el   = 0;
                m_ack  = accept;
                m_idle = 0;
                if (expire) m_fired = 1'b1;
            end else begin
                m_ack  = 1'b0;
                m_idle = (in_run && !kick) ? m_idle + 1 : 0;
                if (m_el < int'(A + R) + 1) m_el++;
                if (m_el == int'(A + R) && m_count < int'(CMAX)) m_count++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; kick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({rst_n, done, ack, count, fired} !== '0) begin
                n_errors++;
                $display("FAIL reset cycle %0d: rst_n=%b done=%b ack=%b count=%0d fired=%b want all 0",
                         i, rst_n, done, ack, count, fired);
            end
        end
    endtask

    task automatic test_power_on();
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            n_checks++;
            if (rst_n !== (c >= int'(A)) || done !== (c >= int'(A + R)) || ack !== 1'b0) begin
                n_errors++;
                $display("FAIL power_on cycle %0d: rst_n=%b done=%b ack=%b want %b %b 0",
                         c, rst_n, done, ack, c >= int'(A), c >= int'(A + R));
            end
            cyc();
        end
        n_checks++;
        if (count !== CW'(1)) begin
            n_errors++;
            $display("FAIL power_on count: got %0d want 1", count);
        end
    endtask

    task automatic test_sw_reset();
        req = 1'b1; cyc(); req = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            n_checks++;
            if (ack !== (j == 1) || rst_n !== (j >= int'(A) + 1) || done !== (j >= int'(A + R) + 1)) begin
                n_errors++;
                $display("FAIL sw_reset k+%0d: ack=%b rst_n=%b done=%b want %b %b %b",
                         j, ack, rst_n, done, j == 1, j >= int'(A) + 1, j >= int'(A + R) + 1);
            end
            cyc();
        end
        n_checks++;
        if (count !== CW'(2)) begin
            n_errors++;
            $display("FAIL sw_reset count: got %0d want 2", count);
        end
    endtask

    task automatic test_release_abort();
        req = 1'b1; cyc(); req = 1'b0;
        repeat (A + 2) cyc();
        n_checks++;
        if (rst_n !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort in_release: rst_n=%b done=%b want 1 0", rst_n, done);
        end
        req = 1'b1; cyc(); req = 1'b0;
        n_checks++;
        if (ack !== 1'b1 || rst_n !== 1'b0 || count !== CW'(2)) begin
            n_errors++;
            $display("FAIL abort restart: ack=%b rst_n=%b count=%0d want 1 0 2", ack, rst_n, count);
        end
        repeat (A + R + 1) cyc();
        n_checks++;
        if (done !== 1'b1 || count !== CW'(3)) begin
            n_errors++;
            $display("FAIL abort complete: done=%b count=%0d want 1 3", done, count);
        end
    endtask

    task automatic test_held_request();
        int acks = 0;
        req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (ack === 1'b1) acks++;
        end
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 1) begin
            n_errors++;
            $display("FAIL held_request acks: got %0d want 1", acks);
        end
        n_checks++;
        if (done !== 1'b1 || count !== CW'(CMAX)) begin
            n_errors++;
            $display("FAIL held_request end: done=%b count=%0d want 1 %0d", done, count, CMAX);
        end
    endtask

    task automatic test_retrigger();
        req = 1'b1; cyc(); req = 1'b0;
        repeat (8) cyc();
        n_checks++;
        if (rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL retrigger mid_assert: rst_n=%b want 0", rst_n);
        end
        req = 1'b1; cyc(); req = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            n_checks++;
            if (ack !== (j == 1) || rst_n !== (j >= int'(A) + 1) || done !== (j >= int'(A + R) + 1)) begin
                n_errors++;
                $display("FAIL retrigger second_ack+%0d: ack=%b rst_n=%b done=%b", j, ack, rst_n, done);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; cyc(); req = 1'b0;
        repeat (A + 1) cyc();
        n_checks++;
        if (rst_n !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid in_release: rst_n=%b done=%b want 1 0", rst_n, done);
        end
        rst = 1'b1; cyc();
        n_checks++;
        if (rst_n !== 1'b0 || count !== '0 || ack !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid after_rst: rst_n=%b count=%0d ack=%b done=%b want 0 0 0 0",
                     rst_n, count, ack, done);
        end
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            n_checks++;
            if (rst_n !== (c >= int'(A)) || done !== (c >= int'(A + R))) begin
                n_errors++;
                $display("FAIL reset_mid restart cycle %0d: rst_n=%b done=%b", c, rst_n, done);
            end
            cyc();
        end
        n_checks++;
        if (count !== CW'(1)) begin
            n_errors++;
            $display("FAIL reset_mid count: got %0d want 1", count);
        end
    endtask

    task automatic test_saturation();
        for (int n = 2; n <= 5; n++) begin
            req = 1'b1; cyc(); req = 1'b0;
            repeat (A + R) cyc();
            n_checks++;
            if (count !== CW'((n > int'(CMAX)) ? CMAX : n)) begin
                n_errors++;
                $display("FAIL saturation seq %0d: count=%0d", n, count);
            end
        end
    endtask

    task automatic test_req_through_reset();
        int acks = 0;
        req = 1'b1; rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (ack === 1'b1) acks++;
            n_checks++;
            if (ack !== (c == 1) || rst_n !== (c >= int'(A) + 1)) begin
                n_errors++;
                $display("FAIL req_through_reset cycle %0d: ack=%b rst_n=%b", c, ack, rst_n);
            end
            cyc();
        end
        req = 1'b0;
        cyc();
        n_checks++;
        if (acks != 1 || count !== CW'(1)) begin
            n_errors++;
            $display("FAIL req_through_reset end: acks=%0d count=%0d want 1 1", acks, count);
        end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 3000; i++) begin
            bias = 2 + (i / 500);
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) req = ~req;
            kick = ($urandom_range(0, 7) < bias);
            cyc();
            n_checks++;
            if (rst_n !== (m_el >= int'(A)) || done !== (m_el >= int'(A + R)) || ack !== m_ack
                || count !== CW'(m_count) || fired !== m_fired) begin
                n_errors++;
                $display("FAIL random step %0d: rst_n=%b done=%b ack=%b count=%0d fired=%b want %b %b %b %0d %b",
                         i, rst_n, done, ack, count, fired, m_el >= int'(A), m_el >= int'(A + R),
                         m_ack, m_count, m_fired);
            end
        end
        rst = 1'b0; req = 1'b0; kick = 1'b1;
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_watchdog();
        rst = 1'b1; req = 1'b0; kick = 1'b1; cyc(); rst = 1'b0;
        repeat (A + R + 2) cyc();
        for (int i = 0; i < 56; i++) begin
            kick = (i % 7 == 0);
            cyc();
            n_checks++;
            if (rst_n !== 1'b1 || fired !== 1'b0) begin
                n_errors++;
                $display("FAIL wdog kicked step %0d: rst_n=%b fired=%b want 1 0", i, rst_n, fired);
            end
        end
        kick = 1'b1; cyc(); kick = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            n_checks++;
            if (rst_n !== (t < 9) || fired !== (t == 9) || ack !== 1'b0) begin
                n_errors++;
                $display("FAIL wdog expiry clear+%0d: rst_n=%b fired=%b ack=%b want %b %b 0",
                         t, rst_n, fired, ack, t < 9, t == 9);
            end
            if (t < 9) cyc();
        end
        kick = 1'b1;
        repeat (30) cyc();
        n_checks++;
        if (fired !== 1'b1 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog sticky: fired=%b done=%b want 1 1", fired, done);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_checks++;
        if (fired !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog cleared_by_rst: fired=%b want 0", fired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_on();
        test_sw_reset();
        test_release_abort();
        test_held_request();
        test_retrigger();
        test_reset_mid();
        test_saturation();
        test_req_through_reset();
        test_random();
`ifdef RST_SEQ_WDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
